// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges execute results and load data onto one register-file
// write port, parking a colliding execute result in a one-entry buffer.
module wb_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ex_valid,
  input  logic        i_ex_is_jal,
  input  logic [4:0]  i_ex_rd,
  input  logic [31:0] i_ex_alu_data,
  input  logic [31:0] i_ex_pc_four,
  output logic        o_ex_ready,
  input  logic        i_ld_valid,
  input  logic [4:0]  i_ld_rd,
  input  logic [31:0] i_ld_data,
  output logic        o_ld_ready,
  output logic [1:0]  o_wb_sel,
  output logic [31:0] o_alu_data,
  output logic [31:0] o_ld_data,
  output logic [31:0] o_pc_four,
  output logic        o_rd_wren,
  output logic [4:0]  o_rd_addr
);

  localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(STARVE_MAX);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;
  localparam logic [1:0] SEL_IDLE = 2'b11;

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_HELD = 2'd1,
    SRC_LOAD = 2'd2,
    SRC_EX   = 2'd3
  } src_e;

  typedef struct packed {
    logic        is_jal;
    logic [4:0]  rd;
    logic [31:0] alu_data;
    logic [31:0] pc_four;
  } ex_entry_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  ex_entry_t        hold_q, hold_d;

  logic [1:0]  wb_sel_q, wb_sel_d;
  logic        rd_wren_q, rd_wren_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [31:0] alu_data_q, alu_data_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic [31:0] pc_four_q, pc_four_d;

  ex_entry_t ex_in;
  ex_entry_t issue_ent;
  src_e      src;
  logic      force_issue;
  logic      ld_ready;
  logic      ex_ready;
  logic      ld_fire;
  logic      ex_fire;
  logic      held_issue;

  // Handshake: a forced held entry blocks loads; the buffer accepts a new
  // execute result only when it is empty or draining this cycle.
  always_comb begin
    ex_in       = '{is_jal: i_ex_is_jal, rd: i_ex_rd,
                    alu_data: i_ex_alu_data, pc_four: i_ex_pc_four};
    force_issue = (state_q == HELD) && (starve_cnt_q == STARVE_LIMIT);
    ld_ready    = !force_issue;
    ld_fire     = i_ld_valid && ld_ready && !i_rst;
    held_issue  = (state_q == HELD) && (force_issue || !ld_fire);
    ex_ready    = (state_q == EMPTY) || held_issue;
    ex_fire     = i_ex_valid && ex_ready && !i_rst;
  end

  // During reset the handshake reflects the reset state, but nothing is accepted.
  assign o_ex_ready = ex_ready || i_rst;
  assign o_ld_ready = ld_ready || i_rst;

  always_comb begin
    src = SRC_NONE;
    if (force_issue) begin
      src = SRC_HELD;
    end else if (ld_fire) begin
      src = SRC_LOAD;
    end else if (state_q == HELD) begin
      src = SRC_HELD;
    end else if (ex_fire) begin
      src = SRC_EX;
    end
  end

  // NOTE: every variable driven here gets a default first, so no path leaves a latch.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    hold_d       = hold_q;
    case (state_q)
      EMPTY: begin
        starve_cnt_d = '0;
        if (ex_fire && ld_fire) begin
          hold_d  = ex_in;
          state_d = HELD;
        end
      end
      HELD: begin
        if (held_issue) begin
          starve_cnt_d = '0;
          if (ex_fire) begin
            hold_d = ex_in;
          end else begin
            state_d = EMPTY;
          end
        end else if (starve_cnt_q != STARVE_LIMIT) begin
          starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d      = EMPTY;
        starve_cnt_d = '0;
      end
    endcase
  end

  // Writeback register next-state: data outputs not selected keep their value.
  always_comb begin
    issue_ent  = (src == SRC_HELD) ? hold_q : ex_in;
    wb_sel_d   = SEL_IDLE;
    rd_wren_d  = 1'b0;
    rd_addr_d  = rd_addr_q;
    alu_data_d = alu_data_q;
    ld_data_d  = ld_data_q;
    pc_four_d  = pc_four_q;
    case (src)
      SRC_LOAD: begin
        wb_sel_d  = SEL_LOAD;
        rd_addr_d = i_ld_rd;
        rd_wren_d = |i_ld_rd;
        ld_data_d = i_ld_data;
      end
      SRC_HELD, SRC_EX: begin
        rd_addr_d = issue_ent.rd;
        rd_wren_d = |issue_ent.rd;
        if (issue_ent.is_jal) begin
          wb_sel_d  = SEL_PC4;
          pc_four_d = issue_ent.pc_four;
        end else begin
          wb_sel_d   = SEL_ALU;
          alu_data_d = issue_ent.alu_data;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see
  // the same pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= EMPTY;
      starve_cnt_q <= '0;
      wb_sel_q     <= SEL_IDLE;
      rd_wren_q    <= 1'b0;
      rd_addr_q    <= '0;
      alu_data_q   <= '0;
      ld_data_q    <= '0;
      pc_four_q    <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      wb_sel_q     <= wb_sel_d;
      rd_wren_q    <= rd_wren_d;
      rd_addr_q    <= rd_addr_d;
      alu_data_q   <= alu_data_d;
      ld_data_q    <= ld_data_d;
      pc_four_q    <= pc_four_d;
    end
  end

  // NOTE: the hold buffer payload is not reset; state_q == EMPTY already marks
  // it invalid, so clearing it would only cost reset fan-out.
  always_ff @(posedge i_clk) begin
    hold_q <= hold_d;
  end

  assign o_wb_sel   = wb_sel_q;
  assign o_rd_wren  = rd_wren_q;
  assign o_rd_addr  = rd_addr_q;
  assign o_alu_data = alu_data_q;
  assign o_ld_data  = ld_data_q;
  assign o_pc_four  = pc_four_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, single issue, collision, starvation,
// x0 writes, replacement in HELD and reset while HELD.
module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_is_jal;
  logic [4:0]  ex_rd;
  logic [31:0] ex_alu_data;
  logic [31:0] ex_pc_four;
  logic        ex_ready;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic [1:0]  wb_sel;
  logic [31:0] alu_data;
  logic [31:0] ld_data_o;
  logic [31:0] pc_four;
  logic        rd_wren;
  logic [4:0]  rd_addr;

  int n_checks = 0;
  int n_errors = 0;

  wb_arbiter #(.STARVE_MAX(4)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_ex_valid    (ex_valid),
    .i_ex_is_jal   (ex_is_jal),
    .i_ex_rd       (ex_rd),
    .i_ex_alu_data (ex_alu_data),
    .i_ex_pc_four  (ex_pc_four),
    .o_ex_ready    (ex_ready),
    .i_ld_valid    (ld_valid),
    .i_ld_rd       (ld_rd),
    .i_ld_data     (ld_data),
    .o_ld_ready    (ld_ready),
    .o_wb_sel      (wb_sel),
    .o_alu_data    (alu_data),
    .o_ld_data     (ld_data_o),
    .o_pc_four     (pc_four),
    .o_rd_wren     (rd_wren),
    .o_rd_addr     (rd_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic jal, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] pc4);
    ex_valid    = v;
    ex_is_jal   = jal;
    ex_rd       = rd;
    ex_alu_data = alu;
    ex_pc_four  = pc4;
  endtask

  task automatic set_ld(input logic v, input logic [4:0] rd, input logic [31:0] d);
    ld_valid = v;
    ld_rd    = rd;
    ld_data  = d;
  endtask

  task automatic idle_inputs();
    set_ex(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    set_ld(1'b0, 5'd0, 32'h0);
  endtask

  task automatic expect_wb(input string tag, input logic [1:0] sel,
                           input logic wren, input logic [4:0] rd);
    check({tag, ".sel"},  32'(wb_sel),  32'(sel));
    check({tag, ".wren"}, 32'(rd_wren), 32'(wren));
    check({tag, ".rd"},   32'(rd_addr), 32'(rd));
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    // Offered transfers during reset must be ignored.
    set_ex(1'b1, 1'b0, 5'd7, 32'hDEAD, 32'h0);
    set_ld(1'b1, 5'd9, 32'hBEEF);
    tick();
    tick();
    #1;
    expect_wb("rst", 2'b11, 1'b0, 5'd0);
    check("rst.alu",  alu_data,  32'h0);
    check("rst.ld",   ld_data_o, 32'h0);
    check("rst.pc4",  pc_four,   32'h0);
    check("rst.exrdy", 32'(ex_ready), 32'd1);
    check("rst.ldrdy", 32'(ld_ready), 32'd1);
    idle_inputs();
    rst = 1'b0;
    tick();
    expect_wb("post_rst", 2'b11, 1'b0, 5'd0);

    // Single ALU result.
    set_ex(1'b1, 1'b0, 5'd5, 32'h1234, 32'h0);
    #1;
    check("alu.exrdy", 32'(ex_ready), 32'd1);
    tick();
    idle_inputs();
    expect_wb("alu", 2'b00, 1'b1, 5'd5);
    check("alu.data", alu_data, 32'h1234);
    tick();
    expect_wb("alu_idle", 2'b11, 1'b0, 5'd5);
    check("alu_idle.data", alu_data, 32'h1234);

    // Collision: load wins, jal result follows next cycle.
    set_ex(1'b1, 1'b1, 5'd1, 32'hDEAD, 32'h104);
    set_ld(1'b1, 5'd2, 32'hAA);
    #1;
    check("col.exrdy", 32'(ex_ready), 32'd1);
    check("col.ldrdy", 32'(ld_ready), 32'd1);
    tick();
    idle_inputs();
    expect_wb("col.ld", 2'b01, 1'b1, 5'd2);
    check("col.ld.data", ld_data_o, 32'hAA);
    #1;
    check("col.held_exrdy", 32'(ex_ready), 32'd1);
    tick();
    expect_wb("col.jal", 2'b10, 1'b1, 5'd1);
    check("col.jal.pc4", pc_four, 32'h104);
    check("col.jal.alu_kept", alu_data, 32'h1234);
    check("col.jal.ld_kept", ld_data_o, 32'hAA);
    tick();
    expect_wb("col.idle", 2'b11, 1'b0, 5'd1);

    // Load to x0 issues but does not write.
    set_ld(1'b1, 5'd0, 32'h55);
    tick();
    idle_inputs();
    expect_wb("x0", 2'b01, 1'b0, 5'd0);
    check("x0.data", ld_data_o, 32'h55);

    // Starvation: held ALU entry loses to 4 loads, then is forced through.
    set_ex(1'b1, 1'b0, 5'd3, 32'h33, 32'h0);
    set_ld(1'b1, 5'd4, 32'h40);
    tick();
    set_ex(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    expect_wb("stv.first", 2'b01, 1'b1, 5'd4);
    check("stv.first.data", ld_data_o, 32'h40);
    for (int i = 0; i < 4; i++) begin
      set_ld(1'b1, 5'(10 + i), 32'h100 + 32'(i));
      #1;
      check($sformatf("stv.ldrdy%0d", i), 32'(ld_ready), 32'd1);
      check($sformatf("stv.exrdy%0d", i), 32'(ex_ready), 32'd0);
      tick();
      expect_wb($sformatf("stv.ld%0d", i), 2'b01, 1'b1, 5'(10 + i));
      check($sformatf("stv.ld%0d.data", i), ld_data_o, 32'h100 + 32'(i));
    end
    set_ld(1'b1, 5'd20, 32'h200);
    #1;
    check("stv.force_ldrdy", 32'(ld_ready), 32'd0);
    check("stv.force_exrdy", 32'(ex_ready), 32'd1);
    tick();
    expect_wb("stv.forced", 2'b00, 1'b1, 5'd3);
    check("stv.forced.alu", alu_data, 32'h33);
    check("stv.forced.ld_kept", ld_data_o, 32'h103);
    #1;
    check("stv.resume_ldrdy", 32'(ld_ready), 32'd1);
    tick();
    idle_inputs();
    expect_wb("stv.resume", 2'b01, 1'b1, 5'd20);
    check("stv.resume.data", ld_data_o, 32'h200);
    tick();
    expect_wb("stv.idle", 2'b11, 1'b0, 5'd20);

    // Replacement in HELD: held entry issues while a new one is captured.
    set_ex(1'b1, 1'b0, 5'd8, 32'h88, 32'h0);
    set_ld(1'b1, 5'd9, 32'h99);
    tick();
    set_ld(1'b0, 5'd0, 32'h0);
    set_ex(1'b1, 1'b1, 5'd11, 32'h0, 32'hBB0);
    expect_wb("rep.ld", 2'b01, 1'b1, 5'd9);
    #1;
    check("rep.exrdy", 32'(ex_ready), 32'd1);
    tick();
    idle_inputs();
    expect_wb("rep.old", 2'b00, 1'b1, 5'd8);
    check("rep.old.alu", alu_data, 32'h88);
    tick();
    expect_wb("rep.new", 2'b10, 1'b1, 5'd11);
    check("rep.new.pc4", pc_four, 32'hBB0);
    tick();
    expect_wb("rep.idle", 2'b11, 1'b0, 5'd11);

    // Reset while HELD discards the held entry.
    set_ex(1'b1, 1'b0, 5'd6, 32'h66, 32'h0);
    set_ld(1'b1, 5'd7, 32'h77);
    tick();
    idle_inputs();
    expect_wb("rh.ld", 2'b01, 1'b1, 5'd7);
    rst = 1'b1;
    #1;
    check("rh.rst_exrdy", 32'(ex_ready), 32'd1);
    check("rh.rst_ldrdy", 32'(ld_ready), 32'd1);
    tick();
    rst = 1'b0;
    expect_wb("rh.after", 2'b11, 1'b0, 5'd0);
    check("rh.after.alu", alu_data, 32'h0);
    tick();
    expect_wb("rh.idle1", 2'b11, 1'b0, 5'd0);
    tick();
    expect_wb("rh.idle2", 2'b11, 1'b0, 5'd0);
    check("rh.idle2.alu", alu_data, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
